// File: rtl/gpio_edge_irq.sv
// Per-bit rising/falling edge capture into sticky W1C status plus a masked level interrupt; optional event counter under GPIO_EDGE_IRQ_CNT_EN.
// Latency: an input change sampled at edge k sets status at edge k and irq at edge k+1.
// Backpressure: none; every cycle is consumed, and a set wins over a clear of the same bit.
module gpio_edge_irq #(
    parameter int C_DWIDTH    = 32,
    parameter int C_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [C_DWIDTH-1:0]    gpio_in,
    input  logic [C_DWIDTH-1:0]    rise_en,
    input  logic [C_DWIDTH-1:0]    fall_en,
    input  logic [C_DWIDTH-1:0]    irq_en,
    input  logic                   global_irq_en,
    input  logic                   clr_valid,
    input  logic [C_DWIDTH-1:0]    clr_mask,
    output logic [C_DWIDTH-1:0]    status,
    output logic                   irq,
    output logic [C_CNT_WIDTH-1:0] event_cnt
);

    typedef enum logic {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [C_DWIDTH-1:0] gpio_q;
    logic [C_DWIDTH-1:0] rise;
    logic [C_DWIDTH-1:0] fall;
    logic [C_DWIDTH-1:0] ev;
    logic [C_DWIDTH-1:0] clr_bits;
    logic [C_DWIDTH-1:0] status_d;
    logic                irq_d;

    // PRIME only seeds gpio_q, so the reset-time mismatch against zero never reports an edge.
    always_comb begin
        state_d = state_q;
        rise    = '0;
        fall    = '0;
        ev      = '0;
        case (state_q)
            ST_PRIME: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                rise = gpio_in & ~gpio_q;
                fall = ~gpio_in & gpio_q;
                ev   = (rise & rise_en) | (fall & fall_en);
            end
            default: begin
                state_d = ST_PRIME;
            end
        endcase
        clr_bits = clr_valid ? clr_mask : '0;
        status_d = (status & ~clr_bits) | ev;
        irq_d    = global_irq_en & (|(status & irq_en));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_PRIME;
            gpio_q  <= '0;
            status  <= '0;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            gpio_q  <= gpio_in;
            status  <= status_d;
            irq     <= irq_d;
        end
    end

`ifdef GPIO_EDGE_IRQ_CNT_EN
    logic [C_CNT_WIDTH-1:0] cnt_q;
    logic                   any_ev;
    logic                   clr_all;

    assign any_ev  = |ev;
    assign clr_all = clr_valid & (&clr_mask);

    // Counts cycles carrying any event; holds at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr_all) begin
            cnt_q <= any_ev ? C_CNT_WIDTH'(1) : '0;
        end else if (any_ev && !(&cnt_q)) begin
            cnt_q <= cnt_q + C_CNT_WIDTH'(1);
        end
    end

    assign event_cnt = cnt_q;
`else
    assign event_cnt = '0;
`endif

endmodule

// File: tb/tb_gpio_edge_irq.sv
// Scoreboard bench for gpio_edge_irq: each row drives one cycle and queues the expected post-edge state.
module tb_gpio_edge_irq;

`ifdef GPIO_EDGE_IRQ_CNT_EN
    localparam bit CNT_BUILT = 1'b1;
`else
    localparam bit CNT_BUILT = 1'b0;
`endif
    localparam bit NC = !CNT_BUILT;
    localparam logic [31:0] D = 32'hFFFF_FFFF;
    localparam logic [31:0] M = 32'h8000_0021;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_in, rise_en, fall_en, irq_en, clr_mask;
    logic        global_irq_en, clr_valid;
    logic [31:0] status;
    logic        irq;
    logic [3:0]  event_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        rst;
        logic [31:0] g;
        logic [31:0] re;
        logic [31:0] fe;
        logic [31:0] ie;
        logic        gie;
        logic        cv;
        logic [31:0] cm;
        logic [31:0] es;
        logic        ei;
        logic [3:0]  ec;
        logic        cc;
    } row_t;

    typedef struct packed {
        logic [31:0] status;
        logic        irq;
        logic [3:0]  cnt;
        logic        chk_cnt;
    } exp_t;

    exp_t sb[$];

    gpio_edge_irq #(.C_DWIDTH(32), .C_CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .gpio_in(gpio_in), .rise_en(rise_en),
        .fall_en(fall_en), .irq_en(irq_en), .global_irq_en(global_irq_en),
        .clr_valid(clr_valid), .clr_mask(clr_mask), .status(status),
        .irq(irq), .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    function automatic row_t mk(input logic rst, input logic [31:0] g, input logic [31:0] re,
                                input logic [31:0] fe, input logic [31:0] ie, input logic gie,
                                input logic cv, input logic [31:0] cm, input logic [31:0] es,
                                input logic ei, input logic [3:0] ec, input logic cc);
        row_t r;
        r.rst = rst; r.g = g; r.re = re; r.fe = fe; r.ie = ie; r.gie = gie;
        r.cv = cv; r.cm = cm; r.es = es; r.ei = ei; r.ec = ec; r.cc = cc;
        return r;
    endfunction

    task automatic drive_push(input row_t r);
        exp_t e;
        reset = r.rst; gpio_in = r.g; rise_en = r.re; fall_en = r.fe;
        irq_en = r.ie; global_irq_en = r.gie; clr_valid = r.cv; clr_mask = r.cm;
        e.status = r.es; e.irq = r.ei; e.cnt = r.ec; e.chk_cnt = r.cc;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        row_t rows[$];
        exp_t e;
        for (int i = 0; i < 3; i++) rows.push_back(mk(1, D, D, D, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(0, D, D, D, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(0, D, D, D, D, 1, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(0, D, D, D, D, 1, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(0, 0, 0, 0, D, 1, 0, 0, 0, 0, 0, 1));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL reset[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL reset[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL reset[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rise();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0, NC));
        rows.push_back(mk(0, 1, 1, 0, 1, 1, 0, 0, 1, 1, 0, NC));
        rows.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, NC));
        rows.push_back(mk(0, 0, 1, 0, 1, 1, 1, 1, 0, 1, 0, NC));
        rows.push_back(mk(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, NC));
        rows.push_back(mk(0, 0, D, D, 1, 1, 0, 0, 0, 0, 0, NC));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL rise[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL rise[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL rise[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_fall_mask();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, 32'h100, 0, 32'h100, 0, 1, 0, 0, 0, 0, 0, NC));
        rows.push_back(mk(0, 0, 0, 32'h100, 0, 1, 0, 0, 32'h100, 0, 0, NC));
        rows.push_back(mk(0, 0, 0, 32'h100, 0, 1, 0, 0, 32'h100, 0, 0, NC));
        rows.push_back(mk(0, 0, 0, 32'h100, 32'h100, 1, 0, 0, 32'h100, 1, 0, NC));
        rows.push_back(mk(0, 0, 0, 32'h100, 32'h100, 1, 1, 32'h100, 0, 1, 0, NC));
        rows.push_back(mk(0, 0, 0, 32'h100, 32'h100, 1, 0, 0, 0, 0, 0, NC));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL fall[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL fall[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL fall[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collision();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, 8, 8, 0, 8, 1, 0, 0, 8, 0, 0, NC));
        rows.push_back(mk(0, 0, 8, 0, 8, 1, 0, 0, 8, 1, 0, NC));
        rows.push_back(mk(0, 8, 8, 0, 8, 1, 1, 8, 8, 1, 0, NC));
        rows.push_back(mk(0, 8, 8, 0, 8, 1, 1, 8, 0, 1, 0, NC));
        rows.push_back(mk(0, 8, 8, 0, 8, 1, 0, 0, 0, 0, 0, NC));
        rows.push_back(mk(0, 8, 8, 0, 8, 1, 1, 32'h10, 0, 0, 0, NC));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL collide[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL collide[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL collide[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_multi();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(0, 0, 0, 0, D, 0, 0, 0, 0, 0, 0, NC));
        rows.push_back(mk(0, M, D, 0, D, 0, 0, 0, M, 0, 0, NC));
        rows.push_back(mk(0, M, D, 0, D, 0, 0, 0, M, 0, 0, NC));
        rows.push_back(mk(0, M, D, 0, D, 1, 0, 0, M, 1, 0, NC));
        rows.push_back(mk(0, M, D, 0, D, 1, 1, D, 0, 1, 0, NC));
        rows.push_back(mk(0, M, D, 0, D, 1, 0, 0, 0, 0, 0, NC));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL multi[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL multi[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL multi[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    // Toggle bit 1 every cycle while clearing it every cycle: each new edge must win over the clear.
    task automatic test_back_to_back();
        row_t rows[$];
        exp_t e;
        for (int i = 0; i < 6; i++)
            rows.push_back(mk(0, (i % 2 == 0) ? (M | 32'h2) : M, 2, 2, 2, 1, 1, 2,
                              2, (i == 0) ? 1'b0 : 1'b1, 0, NC));
        rows.push_back(mk(0, M, 2, 2, 2, 1, 1, 2, 0, 1, 0, NC));
        rows.push_back(mk(0, M, 2, 2, 2, 1, 0, 0, 0, 0, 0, NC));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL b2b[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL b2b[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL b2b[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    task automatic test_counter();
        row_t rows[$];
        exp_t e;
        logic [3:0] c;
        rows.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        rows.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
        for (int i = 0; i < 20; i++) begin
            c = CNT_BUILT ? ((i + 1 > 15) ? 4'hF : 4'(i + 1)) : 4'h0;
            rows.push_back(mk(0, (i % 2 == 0) ? 32'h1 : 32'h0, 1, 1, 0, 0, 0, 0, 1, 0, c, 1));
        end
        rows.push_back(mk(0, 0, 1, 1, 0, 0, 1, D, 0, 0, 0, 1));
        rows.push_back(mk(0, 1, 1, 1, 0, 0, 1, D, 1, 0, CNT_BUILT ? 4'h1 : 4'h0, 1));
        rows.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, CNT_BUILT ? 4'h1 : 4'h0, 1));
        foreach (rows[i]) begin
            drive_push(rows[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++;
            if (status !== e.status) $display("FAIL cnt[%0d] status got %h want %h", i, status, e.status);
            else n_pass++;
            n_checks++;
            if (irq !== e.irq) $display("FAIL cnt[%0d] irq got %b want %b", i, irq, e.irq);
            else n_pass++;
            if (e.chk_cnt) begin
                n_checks++;
                if (event_cnt !== e.cnt) $display("FAIL cnt[%0d] event_cnt got %h want %h", i, event_cnt, e.cnt);
                else n_pass++;
            end
        end
    endtask

    initial begin
        reset = 1'b1; gpio_in = '0; rise_en = '0; fall_en = '0; irq_en = '0;
        global_irq_en = 1'b0; clr_valid = 1'b0; clr_mask = '0;
        test_reset();
        test_rise();
        test_fall_mask();
        test_collision();
        test_multi();
        test_back_to_back();
        test_counter();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
